// File: rtl/rtc_calendar_counter_if.sv
// Bus between the time-setting block and the RTC calendar counter.
// master: the time-setting side (drives set_* fields, run and load and
//         consumes the current time).
// slave:  the calendar counter itself.
interface rtc_calendar_counter_if;
    logic        run;
    logic        load;
    logic [15:0] set_year;
    logic [7:0]  set_month;
    logic [7:0]  set_day;
    logic [7:0]  set_hour;
    logic [7:0]  set_minute;
    logic [7:0]  set_sec;
    logic [3:0]  set_week;

    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  sec;
    logic [3:0]  week;
    logic        sec_tick;

    modport master (
        output run, load,
        output set_year, set_month, set_day, set_hour, set_minute, set_sec, set_week,
        input  year, month, day, hour, minute, sec, week, sec_tick
    );

    modport slave (
        input  run, load,
        input  set_year, set_month, set_day, set_hour, set_minute, set_sec, set_week,
        output year, month, day, hour, minute, sec, week, sec_tick
    );
endinterface

// File: rtl/rtc_calendar_counter.sv
// Free-running BCD real-time clock and calendar.
// A divider produces one tick every CLK_HZ cycles; on each tick the
// seconds advance and carries ripple through minutes, hours, days, months
// and years in a single cycle, with Gregorian leap years and a weekday
// counter. A load strobe replaces the whole snapshot and restarts the
// divider. All outputs are registered.
module rtc_calendar_counter #(
    parameter int CLK_HZ = 100000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rtc_calendar_counter_if.slave bus
);

    localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    // Reset snapshot: 2023-01-01 00:00:00, a Sunday.
    localparam logic [15:0] RST_YEAR  = 16'h2023;
    localparam logic [7:0]  RST_MONTH = 8'h01;
    localparam logic [7:0]  RST_DAY   = 8'h01;
    localparam logic [3:0]  RST_WEEK  = 4'd0;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Two-digit BCD increment without range wrap; units 9 rolls to 0.
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
            r[3:0] = 4'd0;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Four-digit BCD increment; 9999 wraps naturally to 0000.
    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two BCD digits to binary (0..99 for legal digits).
    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
    endfunction

    // Gregorian leap test from BCD digits. When the low two digits are 00
    // the century digits decide (covers the /100 and /400 rules together).
    function automatic logic is_leap(input logic [15:0] y);
        logic [7:0] part;
        if (y[7:0] != 8'h00) begin
            part = bcd2bin(y[7:0]);
        end else begin
            part = bcd2bin(y[15:8]);
        end
        return (part[1:0] == 2'b00);
    endfunction

    // Last day of the month in BCD. Illegal months fall back to 31 so a
    // bad loaded month still rolls over and self-corrects.
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
        logic [7:0] d;
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            8'h02:                      d = leap ? 8'h29 : 8'h28;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [15:0]      year_q;
    logic [7:0]       month_q;
    logic [7:0]       day_q;
    logic [7:0]       hour_q;
    logic [7:0]       minute_q;
    logic [7:0]       sec_q;
    logic [3:0]       week_q;
    logic             sec_tick_q;

    logic [15:0] year_nxt;
    logic [7:0]  month_nxt;
    logic [7:0]  day_nxt;
    logic [7:0]  hour_nxt;
    logic [7:0]  minute_nxt;
    logic [7:0]  sec_nxt;
    logic [3:0]  week_nxt;
    logic        carry_min;
    logic        carry_hour;
    logic        carry_day;
    logic        carry_month;
    logic        carry_year;
    logic        leap;
    logic [7:0]  dim;
    logic        tick_now;

    // Divider terminal count while running is the one-second event.
    assign tick_now = bus.run && (div_q == DIV_LAST);
    assign leap     = is_leap(year_q);
    assign dim      = days_in_month(month_q, leap);

    // Compute the time one second ahead; every carry resolves in this one pass.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        year_nxt    = year_q;
        month_nxt   = month_q;
        day_nxt     = day_q;
        hour_nxt    = hour_q;
        minute_nxt  = minute_q;
        sec_nxt     = sec_q;
        week_nxt    = week_q;
        carry_min   = 1'b0;
        carry_hour  = 1'b0;
        carry_day   = 1'b0;
        carry_month = 1'b0;
        carry_year  = 1'b0;

        // Fields use >= so an out-of-range loaded value wraps at its next carry.
        if (sec_q >= 8'h59) begin
            sec_nxt   = 8'h00;
            carry_min = 1'b1;
        end else begin
            sec_nxt = bcd_inc8(sec_q);
        end

        if (carry_min) begin
            if (minute_q >= 8'h59) begin
                minute_nxt = 8'h00;
                carry_hour = 1'b1;
            end else begin
                minute_nxt = bcd_inc8(minute_q);
            end
        end

        if (carry_hour) begin
            if (hour_q >= 8'h23) begin
                hour_nxt  = 8'h00;
                carry_day = 1'b1;
            end else begin
                hour_nxt = bcd_inc8(hour_q);
            end
        end

        if (carry_day) begin
            week_nxt = (week_q >= 4'd6) ? 4'd0 : week_q + 4'd1;
            if (day_q >= dim) begin
                day_nxt     = 8'h01;
                carry_month = 1'b1;
            end else begin
                day_nxt = bcd_inc8(day_q);
            end
        end

        if (carry_month) begin
            if (month_q >= 8'h12) begin
                month_nxt  = 8'h01;
                carry_year = 1'b1;
            end else begin
                month_nxt = bcd_inc8(month_q);
            end
        end

        if (carry_year) begin
            year_nxt = bcd_inc16(year_q);
        end
    end

    // Divider, load capture and once-per-second field update.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            div_q      <= '0;
            year_q     <= RST_YEAR;
            month_q    <= RST_MONTH;
            day_q      <= RST_DAY;
            hour_q     <= 8'h00;
            minute_q   <= 8'h00;
            sec_q      <= 8'h00;
            week_q     <= RST_WEEK;
            sec_tick_q <= 1'b0;
        end else if (bus.load) begin
            // Load wins over a coincident tick; that tick is dropped.
            div_q      <= '0;
            year_q     <= bus.set_year;
            month_q    <= bus.set_month;
            day_q      <= bus.set_day;
            hour_q     <= bus.set_hour;
            minute_q   <= bus.set_minute;
            sec_q      <= bus.set_sec;
            week_q     <= bus.set_week;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= tick_now;
            if (bus.run) begin
                div_q <= tick_now ? '0 : div_q + DIV_W'(1);
            end
            if (tick_now) begin
                year_q   <= year_nxt;
                month_q  <= month_nxt;
                day_q    <= day_nxt;
                hour_q   <= hour_nxt;
                minute_q <= minute_nxt;
                sec_q    <= sec_nxt;
                week_q   <= week_nxt;
            end
        end
    end

    assign bus.year     = year_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.hour     = hour_q;
    assign bus.minute   = minute_q;
    assign bus.sec      = sec_q;
    assign bus.week     = week_q;
    assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Directed testbench for rtc_calendar_counter with CLK_HZ = 10.
// Inputs change just after a rising edge or on a falling edge; outputs
// are sampled 1 time unit after the rising edge.
module tb_rtc_calendar_counter;

    localparam int CLK_HZ = 10;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  sec;
        logic [3:0]  week;
    } cal_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rtc_calendar_counter_if bus ();

    rtc_calendar_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cal_t mk(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                                input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                                input logic [3:0] w);
        cal_t c;
        c.year = y; c.month = mo; c.day = d; c.hour = h; c.minute = mi; c.sec = s; c.week = w;
        return c;
    endfunction

    function automatic cal_t snap();
        return mk(bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.sec, bus.week);
    endfunction

    // Present a snapshot on the falling edge, strobe load for one rising edge.
    task automatic do_load(input cal_t c);
        @(negedge clk);
        bus.set_year   = c.year;
        bus.set_month  = c.month;
        bus.set_day    = c.day;
        bus.set_hour   = c.hour;
        bus.set_minute = c.minute;
        bus.set_sec    = c.sec;
        bus.set_week   = c.week;
        bus.load       = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    // Count rising edges until sec_tick is seen; -1 if the budget expires.
    task automatic wait_tick(output int edges);
        edges = -1;
        for (int i = 1; i <= 4 * CLK_HZ; i++) begin
            @(posedge clk);
            #1;
            if (bus.sec_tick === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    // Load a snapshot, run one second, and compare against the expected result.
    task automatic tick_case(input string name, input cal_t ld, input cal_t exp);
        int edges;
        cal_t got;
        do_load(ld);
        got = snap();
        checks++;
        if (got !== ld || bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s load: got %h tick %b, want %h tick 0", name, got, bus.sec_tick, ld);
        end
        wait_tick(edges);
        checks++;
        if (edges != CLK_HZ) begin
            errors++;
            $display("FAIL %s tick_latency: got %0d edges, want %0d", name, edges, CLK_HZ);
        end
        got = snap();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s advance: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        cal_t got;
        rst_n    = 1'b0;
        bus.run  = 1'b0;
        bus.load = 1'b0;
        bus.set_year = '0; bus.set_month = '0; bus.set_day = '0; bus.set_hour = '0;
        bus.set_minute = '0; bus.set_sec = '0; bus.set_week = '0;
        repeat (2) @(posedge clk);
        #1;
        got = snap();
        checks++;
        if (got !== mk(16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0)) begin
            errors++;
            $display("FAIL reset_fields: got %h, want 2023-01-01 00:00:00 w0", got);
        end
        checks++;
        if (bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b, want 0", bus.sec_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_year_rollover();
        bus.run = 1'b1;
        tick_case("year_rollover",
                  mk(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd0),
                  mk(16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1));
        // sec_tick must be a single-cycle pulse.
        @(posedge clk);
        #1;
        checks++;
        if (bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: got %b one cycle after tick, want 0", bus.sec_tick);
        end
    endtask

    task automatic test_plain_second();
        tick_case("sec_units",
                  mk(16'h2023, 8'h06, 8'h15, 8'h12, 8'h34, 8'h09, 4'd4),
                  mk(16'h2023, 8'h06, 8'h15, 8'h12, 8'h34, 8'h10, 4'd4));
        tick_case("hour_units",
                  mk(16'h2023, 8'h06, 8'h15, 8'h09, 8'h59, 8'h59, 4'd4),
                  mk(16'h2023, 8'h06, 8'h15, 8'h10, 8'h00, 8'h00, 4'd4));
    endtask

    task automatic test_leap();
        tick_case("leap_2024",
                  mk(16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd3),
                  mk(16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd4));
        tick_case("noleap_2100",
                  mk(16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd6),
                  mk(16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0));
        tick_case("leap_2000",
                  mk(16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd1),
                  mk(16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd2));
    endtask

    task automatic test_month_rollover();
        tick_case("month_30",
                  mk(16'h2023, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59, 4'd0),
                  mk(16'h2023, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1));
        tick_case("year_9999",
                  mk(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd5),
                  mk(16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd6));
    endtask

    task automatic test_load_priority();
        cal_t a;
        cal_t b;
        cal_t got;
        int   edges;
        a = mk(16'h2023, 8'h07, 8'h04, 8'h10, 8'h20, 8'h30, 4'd2);
        b = mk(16'h2030, 8'h08, 8'h09, 8'h11, 8'h22, 8'h33, 4'd5);
        do_load(a);
        // Nine more edges puts the divider at its terminal count.
        repeat (CLK_HZ - 1) @(posedge clk);
        #1;
        do_load(b);
        got = snap();
        checks++;
        if (got !== b || bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: got %h tick %b, want %h tick 0", got, bus.sec_tick, b);
        end
        wait_tick(edges);
        checks++;
        if (edges != CLK_HZ) begin
            errors++;
            $display("FAIL load_priority_latency: got %0d edges, want %0d", edges, CLK_HZ);
        end
        got = snap();
        checks++;
        if (got !== mk(16'h2030, 8'h08, 8'h09, 8'h11, 8'h22, 8'h34, 4'd5)) begin
            errors++;
            $display("FAIL load_priority_advance: got %h, want 2030-08-09 11:22:34 w5", got);
        end
    endtask

    task automatic test_run_hold();
        cal_t c;
        cal_t got;
        int   ticks_seen;
        int   edges;
        c = mk(2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        c = mk(16'h2025, 8'h03, 8'h15, 8'h08, 8'h45, 8'h10, 4'd6);
        do_load(c);
        repeat (3) @(posedge clk);
        #1;
        bus.run    = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.sec_tick !== 1'b0) ticks_seen++;
        end
        checks++;
        if (ticks_seen != 0) begin
            errors++;
            $display("FAIL hold_no_tick: got %0d ticks, want 0", ticks_seen);
        end
        got = snap();
        checks++;
        if (got !== c) begin
            errors++;
            $display("FAIL hold_fields: got %h, want %h", got, c);
        end
        // Divider held at 3, so seven more running edges reach the tick.
        bus.run = 1'b1;
        wait_tick(edges);
        checks++;
        if (edges != CLK_HZ - 3) begin
            errors++;
            $display("FAIL resume_latency: got %0d edges, want %0d", edges, CLK_HZ - 3);
        end
        got = snap();
        checks++;
        if (got !== mk(16'h2025, 8'h03, 8'h15, 8'h08, 8'h45, 8'h11, 4'd6)) begin
            errors++;
            $display("FAIL resume_advance: got %h, want 2025-03-15 08:45:11 w6", got);
        end
    endtask

    task automatic test_async_reset();
        cal_t got;
        int   edges;
        do_load(mk(16'h2042, 8'h10, 8'h20, 8'h13, 8'h14, 8'h15, 4'd3));
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        got = snap();
        checks++;
        if (got !== mk(16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0) || bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h tick %b, want 2023-01-01 00:00:00 w0 tick 0", got, bus.sec_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(edges);
        checks++;
        if (edges != CLK_HZ) begin
            errors++;
            $display("FAIL reset_divider_restart: got %0d edges, want %0d", edges, CLK_HZ);
        end
        got = snap();
        checks++;
        if (got !== mk(16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 4'd0)) begin
            errors++;
            $display("FAIL reset_first_second: got %h, want 2023-01-01 00:00:01 w0", got);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_year_rollover();
        test_plain_second();
        test_leap();
        test_month_rollover();
        test_load_priority();
        test_run_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_counter.md
Name: rtc_calendar_counter

Overview:
- Free-running BCD real-time clock and calendar that receives the time/date fields produced by the time-setting block and advances them once per second.
- Loads a complete BCD snapshot on a load strobe, then counts seconds through minutes, hours, days, months and years with full Gregorian leap-year handling and weekday tracking.
- Its outputs feed the display and alarm logic.

Parameters:
- CLK_HZ, 100000000, input clock frequency; the 1 Hz tick fires every CLK_HZ cycles (benches set it to a small value, e.g. 10).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = divider counts and time advances; 0 = divider and time frozen
- load  in  1  single-cycle strobe: capture set_* fields
- set_year  in  16  BCD year, 4 digits
- set_month  in  8  BCD month 01-12
- set_day  in  8  BCD day 01-31
- set_hour  in  8  BCD hour 00-23
- set_minute  in  8  BCD minute 00-59
- set_sec  in  8  BCD second 00-59
- set_week  in  4  weekday 0-6, 0 = Sunday
- year  out  16  current BCD year
- month  out  8  current BCD month
- day  out  8  current BCD day
- hour  out  8  current BCD hour
- minute  out  8  current BCD minute
- sec  out  8  current BCD second
- week  out  4  current weekday 0-6
- sec_tick  out  1  one-cycle pulse in the cycle the time fields advance

Behaviour:
- Reset (rst_n low, asynchronous):
  - year = 16'h2023, month = 8'h01, day = 8'h01.
  - hour = minute = sec = 8'h00, week = 0 (2023-01-01 is a Sunday).
  - divider = 0, sec_tick = 0.
  - Releasing reset mid-second restarts the divider from 0.
- Divider:
  - Counter runs 0..CLK_HZ-1 while run = 1 and wraps to 0.
  - The terminal count (CLK_HZ-1) generates the internal tick.
  - With run = 0 the divider holds its value and no tick occurs.
- Load:
  - load = 1 captures all set_* fields verbatim into the outputs on that clock edge (visible the next cycle).
  - The divider is cleared to 0 and sec_tick stays 0 that cycle.
  - Load has priority over a coincident tick; that tick is discarded.
  - Load works regardless of run.
- Tick (registered, one-cycle latency): sec_tick = 1 for one cycle, coincident with the updated fields.
- BCD increment rule for every field: units digit 9 becomes 0 with tens +1.
  - A field at or above its maximum wraps to its minimum and carries.
  - The >= compare makes out-of-range loaded values self-correct at the next carry.
- Field ranges:
  - sec 00-59, carry to minute.
  - minute 00-59, carry to hour.
  - hour 00-23, carry to day.
  - day 01-DIM, carry to month; also advance week.
  - month 01-12, carry to year.
  - year 0000-9999; 9999 wraps to 0000.
- Days in month (DIM):
  - 31 for months 01,03,05,07,08,10,12.
  - 30 for months 04,06,09,11.
  - 28 for 02, or 29 when leap.
- Leap year: divisible by 4 and not by 100, or divisible by 400. Computed from BCD digits:
  - Low two digits not 00: leap if (tens*10+units) mod 4 == 0.
  - Low two digits 00: leap if the upper two digits mod 4 == 0.
- Weekday: increments on every day rollover; 6 wraps to 0. No recomputation from the date; the loaded week value is trusted.
- Simultaneous carries resolve in the same tick; all fields are updated in one cycle.
- No combinational path from set_* inputs to outputs.

Test Plan:
- Reset → year 2023, month 01, day 01, 00:00:00, week 0, sec_tick 0. Assert rst_n low mid-second → outputs return to reset values immediately, without waiting for a clock edge.
- CLK_HZ=10: load 2023-12-31 23:59:59 week 0, run=1; 10 cycles later → 2024-01-01 00:00:00, week 1, sec_tick high exactly one cycle.
- Load 2024-02-28 23:59:59 → one tick → 2024-02-29. Load 2100-02-28 23:59:59 → one tick → 2100-03-01. Load 2000-02-28 23:59:59 → one tick → 2000-02-29.
- Load 2023-04-30 23:59:59 → one tick → 2023-05-01 00:00:00. Load 9999-12-31 23:59:59 → one tick → 0000-01-01.
- Assert load in the divider's terminal-count cycle → loaded values appear unchanged, no sec_tick; next sec_tick exactly CLK_HZ cycles after the load.
- run=0 for 50 cycles → outputs and divider held, no sec_tick. run=1 → counting resumes from the held divider value.
